// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: sequencer state encoding and default operand width.
package arith_pkg;

    localparam int ARITH_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arith_state_t;

endpackage

// File: rtl/Half_Adder.sv
// One-bit half adder: the leaf cell of the arithmetic library.
module Half_Adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_full_adder_cell.sv
// Combinational one-bit full adder built from two half adders and an OR on their carries.
module serial_full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    Half_Adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    Half_Adder u_ha1 (
        .a     (ha0_sum),
        .b     (cin),
        .sum   (sum),
        .carry (ha1_carry)
    );

    // The two half-adder carries can never both be set, so OR is exact.
    assign cout = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder_controller.sv
// Bit-serial adder: one full-adder cell sequenced LSB first over DATA_WIDTH cycles, start/done handshake.
// Optional carry seed input enabled by defining SERIAL_ADDER_CARRY_IN_EN.
module serial_adder_controller
    import arith_pkg::*;
#(
    parameter int DATA_WIDTH = ARITH_DEFAULT_WIDTH
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Start_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
`ifdef SERIAL_ADDER_CARRY_IN_EN
    input  logic                  Carry_In,
`endif
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic [DATA_WIDTH-1:0] Sum_Out,
    output logic                  Carry_Out
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    arith_state_t state_reg;
    arith_state_t state_next;

    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [DATA_WIDTH-1:0] res_reg;
    logic [DATA_WIDTH-1:0] res_next;
    logic [DATA_WIDTH-1:0] sum_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  carry_reg;
    logic                  cout_reg;

    logic start_accept;
    logic last_bit;
    logic carry_seed;
    logic cell_sum;
    logic cell_cout;

`ifdef SERIAL_ADDER_CARRY_IN_EN
    assign carry_seed = Carry_In;
`else
    assign carry_seed = 1'b0;
`endif

    // Starts are honoured in IDLE and DONE; DONE allows back-to-back operation.
    assign start_accept = Start_In && (state_reg != RUN);
    assign last_bit     = (state_reg == RUN) && (cnt_reg == LAST_CNT);

    serial_full_adder_cell u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry_reg),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_comb begin
        res_next                 = res_reg >> 1;
        res_next[DATA_WIDTH-1]   = cell_sum;
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Start_In) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = Start_In ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy_Out = (state_reg == RUN);
        Done_Out = (state_reg == DONE);
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else if (start_accept) begin
            a_reg     <= Data_A_In;
            b_reg     <= Data_B_In;
            res_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= carry_seed;
        end else if (state_reg == RUN) begin
            a_reg     <= a_reg >> 1;
            b_reg     <= b_reg >> 1;
            res_reg   <= res_next;
            carry_reg <= cell_cout;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            // The final bit is folded in directly so the result lands on the RUN->DONE edge.
            if (last_bit) begin
                sum_reg  <= res_next;
                cout_reg <= cell_cout;
            end
        end
    end

    assign Sum_Out   = sum_reg;
    assign Carry_Out = cout_reg;

endmodule

// File: tb/tb_serial_adder_controller.sv
// Directed self-checking bench for serial_adder_controller (8-bit and 1-bit instances).
module tb_serial_adder_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       s1_start;
    logic [0:0] s1_a;
    logic [0:0] s1_b;
    logic       s1_cin;
    logic       s1_busy;
    logic       s1_done;
    logic [0:0] s1_sum;
    logic       s1_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_controller #(.DATA_WIDTH(8)) u_dut (
        .Clock_In  (clk),
        .Reset_In  (rst),
        .Start_In  (start),
        .Data_A_In (a),
        .Data_B_In (b),
`ifdef SERIAL_ADDER_CARRY_IN_EN
        .Carry_In  (cin),
`endif
        .Busy_Out  (busy),
        .Done_Out  (done),
        .Sum_Out   (sum),
        .Carry_Out (cout)
    );

    serial_adder_controller #(.DATA_WIDTH(1)) u_dut1 (
        .Clock_In  (clk),
        .Reset_In  (rst),
        .Start_In  (s1_start),
        .Data_A_In (s1_a),
        .Data_B_In (s1_b),
`ifdef SERIAL_ADDER_CARRY_IN_EN
        .Carry_In  (s1_cin),
`endif
        .Busy_Out  (s1_busy),
        .Done_Out  (s1_done),
        .Sum_Out   (s1_sum),
        .Carry_Out (s1_cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a start for one edge; operands are scrambled afterwards since they need not be held.
    task automatic begin_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_cin);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        cin   = op_cin;
        tick();
        start = 1'b0;
        a     = 8'hA5;
        b     = 8'h5A;
        cin   = 1'b0;
    endtask

    // Called just after the accepted-start edge; walks RUN and checks the DONE cycle.
    task automatic expect_run(input string tag, input logic [7:0] exp_sum, input logic exp_c,
                              input logic [7:0] hold_sum, input logic hold_c, input int glitch_at);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_hold_sum"}, 32'(sum), 32'(hold_sum));
            check({tag, "_hold_c"}, 32'(cout), 32'(hold_c));
            start = (i == glitch_at);
            if (i == glitch_at) begin
                a = 8'h12;
                b = 8'h34;
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_carry"}, 32'(cout), 32'(exp_c));
        $display("op %s: sum=0x%02h carry=%0d (expect 0x%02h/%0d)", tag, sum, cout, exp_sum, exp_c);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        cin      = 1'b0;
        s1_start = 1'b0;
        s1_a     = 1'b0;
        s1_b     = 1'b0;
        s1_cin   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry", 32'(cout), 32'd0);
        check("rst1_busy", 32'(s1_busy), 32'd0);
        tick();

        begin_op(8'h35, 8'h4A, 1'b0);
        expect_run("add_35_4a", 8'h7F, 1'b0, 8'h00, 1'b0, -1);
        tick();
        check("idle_after_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Start pulsed mid-RUN must be ignored; then back-to-back start in the DONE cycle.
        begin_op(8'hFF, 8'h01, 1'b0);
        expect_run("add_ff_01", 8'h00, 1'b1, 8'h7F, 1'b0, 3);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h20;
        tick();
        start = 1'b0;
        a     = 8'hEE;
        b     = 8'hEE;
        expect_run("b2b_10_20", 8'h30, 1'b0, 8'h00, 1'b1, -1);
        tick();
        check("b2b_done_clr", 32'(done), 32'd0);
        check("b2b_sum_keep", 32'(sum), 32'h30);

        // Reset in the 4th RUN cycle discards the partial result.
        begin_op(8'h55, 8'h66, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_carry", 32'(cout), 32'd0);
        tick();
        check("midrst_nodone", 32'(done), 32'd0);
        $display("op mid_run_reset: busy=%0d sum=0x%02h", busy, sum);

        // Reset and start together: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        tick();
        check("rst_start_busy2", 32'(busy), 32'd0);
        check("rst_start_done", 32'(done), 32'd0);
        $display("op reset_with_start: busy=%0d", busy);

        begin_op(8'hFF, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_CARRY_IN_EN
        expect_run("cin_ff_00", 8'h00, 1'b1, 8'h00, 1'b0, -1);
`else
        expect_run("cin_ff_00", 8'hFF, 1'b0, 8'h00, 1'b0, -1);
`endif
        tick();

        // One-bit instance: 1 + 1 = {1, 0}, done two cycles after the start edge.
        s1_start = 1'b1;
        s1_a     = 1'b1;
        s1_b     = 1'b1;
        tick();
        s1_start = 1'b0;
        s1_a     = 1'b0;
        s1_b     = 1'b0;
        check("w1_busy", 32'(s1_busy), 32'd1);
        check("w1_nodone", 32'(s1_done), 32'd0);
        tick();
        check("w1_busy_end", 32'(s1_busy), 32'd0);
        check("w1_done", 32'(s1_done), 32'd1);
        check("w1_sum", 32'(s1_sum), 32'd0);
        check("w1_carry", 32'(s1_cout), 32'd1);
        $display("op w1_1_1: sum=%0d carry=%0d", s1_sum, s1_cout);
        tick();
        check("w1_done_clr", 32'(s1_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_controller.md
# serial_adder_controller

Bit-serial adder that sequences a single one-bit full-adder cell, built from two `Half_Adder` instances and an OR gate, across `DATA_WIDTH` operand bits, LSB first. Used where area matters more than throughput. It is the sequencer sitting above the half-adder datapath in the arithmetic library. The interface is a start/done handshake, and the results are registered and held stable between operations.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: operand and sum width in bits; minimum 1.

Ports:
- `Clock_In`  input  1  the single clock; all state changes on its rising edge.
- `Reset_In`  input  1  synchronous, active-high reset.
- `Start_In`  input  1  request to begin an addition; honoured only when `Busy_Out`=0.
- `Data_A_In`  input  DATA_WIDTH  operand A; sampled only on the accepted-start edge.
- `Data_B_In`  input  DATA_WIDTH  operand B; sampled only on the accepted-start edge.
- `Carry_In`  input  1  carry seed; present only with `SERIAL_ADDER_CARRY_IN_EN`.
- `Busy_Out`  output  1  high while in RUN.
- `Done_Out`  output  1  one-cycle pulse; the result has just been loaded.
- `Sum_Out`  output  DATA_WIDTH  registered sum of the last completed operation.
- `Carry_Out`  output  1  registered carry-out of the last completed operation.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: Start_In=1 → RUN.
  - RUN: exits to DONE after exactly DATA_WIDTH cycles.
  - DONE: lasts one cycle. Start_In=1 → RUN (back-to-back accepted); otherwise → IDLE.
- Accepted start:
  - A and B are loaded into internal shift registers.
  - The bit counter is cleared.
  - The carry register is loaded with 0, or with Carry_In when the macro is enabled.
- Each RUN cycle:
  - Adds A[0], B[0] and the carry through the full-adder cell.
  - Shifts the sum bit into the MSB of the internal result shift register.
  - Shifts A and B right by one.
  - Updates the carry and increments the counter.
- RUN→DONE edge: the result shift register is copied to Sum_Out and the final carry to Carry_Out.
- Sum_Out and Carry_Out change only on that edge or on reset; they hold their previous values during RUN.
- Start_In while in RUN is ignored: no queuing, no error.
- Arithmetic: {Carry_Out, Sum_Out} = A + B (+ Carry_In), i.e. modulo 2^(DATA_WIDTH+1). Inputs are unsigned.
- Counter width: $clog2(DATA_WIDTH+1). The terminal count is DATA_WIDTH−1 on the last RUN cycle.

## Timing
- Reset values: state IDLE; Busy_Out 0; Done_Out 0; Sum_Out 0; Carry_Out 0; internal registers 0.
- A start sampled at edge t gives:
  - Busy_Out high from t+1 through t+DATA_WIDTH.
  - Done_Out high for the single cycle after edge t+DATA_WIDTH+1.
  - Sum_Out/Carry_Out valid from that same edge.
- Latency from start to Done_Out is DATA_WIDTH+1 cycles. Throughput is one operation per DATA_WIDTH+1 cycles when starts are issued back-to-back from DONE.
- Reset asserted in any state, including mid-RUN: next edge returns to the reset values and the partial result is discarded. Reset has priority over Start_In.
- Reset and Start_In high together: reset wins; the start is lost.
- Operand inputs may change freely after the accepted-start edge.

## Configuration
- `SERIAL_ADDER_CARRY_IN_EN` defined:
  - The `Carry_In` port exists.
  - It is sampled on the accepted-start edge and seeds the carry register.
- Not defined:
  - No `Carry_In` port.
  - The carry register is seeded with 0.
- Latency and all other behaviour are identical in both builds.

## Structure
- Shared package `arith_pkg`:
  - State enum (IDLE, RUN, DONE).
  - Default width constant `ARITH_DEFAULT_WIDTH = 8`.
- Sub-module `serial_full_adder_cell`:
  - Pure combinational: A, B, Cin → Sum, Cout.
  - Built from two `Half_Adder` instances plus an OR on the carries.
  - No state inside.
- Top level holds the FSM, counter, shift registers and output registers.

## Test plan
- DATA_WIDTH=8, start with A=0x35, B=0x4A → Busy_Out high for 8 cycles; Done_Out pulse at start+9; Sum_Out=0x7F, Carry_Out=0.
- A=0xFF, B=0x01 → Sum_Out=0x00, Carry_Out=1. Sum_Out holds the previous 0x7F throughout RUN.
- Start_In pulsed at RUN cycle 3 with new operands → ignored; result still 0xFF+0x01. Then start in the DONE cycle with 0x10+0x20 → Done at +9, Sum_Out=0x30.
- Reset_In asserted at RUN cycle 4 → next cycle Busy_Out=0, Sum_Out=0, Carry_Out=0, no Done_Out pulse.
- Macro on: A=0xFF, B=0x00, Carry_In=1 → Sum_Out=0x00, Carry_Out=1. Macro off, same operands → Sum_Out=0xFF, Carry_Out=0.
- DATA_WIDTH=1: A=1, B=1 → Done_Out at start+2, Sum_Out=0, Carry_Out=1.
